// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums M consecutive multiplier products into one dot-product result
//
// Purpose:
//   Takes each product from the upstream shift-add multiplier on its done
//   strobe and accumulates M of them into a dot product. The finished result
//   is held in an output register with a valid/ready handshake. A sticky
//   overrun flag records results lost because the consumer stalled.
//
// Ports:
//   clk        - clock, rising edge active
//   rst_n      - asynchronous active-low reset
//   P          - product from the multiplier (2N bits), qualified by done
//   done       - product-valid strobe, one product per high cycle
//   clear      - synchronous flush of partial sum, count, output valid, flags
//   sum        - completed dot product (ACC_W bits)
//   sum_valid  - sum holds an unconsumed result
//   sum_ready  - consumer accepts sum when sum_valid is high
//   term_count - products in the current partial sum, 0..M-1
//   overrun    - sticky, set when a completed result had to be discarded

module mac_accumulator #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int ACC_W = 2 * N + $clog2(M)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*N-1:0]       P,
  input  logic                 done,
  input  logic                 clear,
  output logic [ACC_W-1:0]     sum,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [$clog2(M)-1:0] term_count,
  output logic                 overrun
);

  localparam int TC_W = $clog2(M);
  localparam logic [TC_W-1:0] LAST_TERM = TC_W'(M - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] acc_next;
  logic             complete;
  logic             accept;

  assign p_ext    = ACC_W'(P);
  // The first term loads P directly, so a stale acc never leaks into a new sum.
  assign acc_next = (term_count == '0) ? p_ext : acc + p_ext;
  assign complete = done && (term_count == LAST_TERM);
  assign accept   = sum_valid && sum_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      term_count <= '0;
      sum        <= '0;
      sum_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      // sum keeps its last value; only the valid qualifier is dropped.
      acc        <= '0;
      term_count <= '0;
      sum_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done) begin
        if (complete) begin
          acc        <= '0;
          term_count <= '0;
        end else begin
          acc        <= acc_next;
          term_count <= term_count + 1'b1;
        end
      end

      if (complete) begin
        // The output slot is free if empty or being drained this very cycle.
        if (!sum_valid || accept) begin
          sum       <= acc_next;
          sum_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        sum_valid <= 1'b0;
      end
    end
  end

endmodule
